// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 Set-2 scan code constants and decoder state encoding
package ps2_pkg;

  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_BRK      = 8'hF0;
  localparam logic [7:0] SC_PAUSE    = 8'hE1;

  localparam logic [7:0] SC_BAT_OK   = 8'hAA;
  localparam logic [7:0] SC_ACK      = 8'hFA;
  localparam logic [7:0] SC_BAT_ERR0 = 8'hFC;
  localparam logic [7:0] SC_BAT_ERR1 = 8'hFD;
  localparam logic [7:0] SC_OVR0     = 8'h00;
  localparam logic [7:0] SC_OVR1     = 8'hFF;
  localparam logic [7:0] SC_RESEND   = 8'hFE;
  localparam logic [7:0] SC_ECHO     = 8'hEE;

  localparam logic [7:0] SC_UP       = 8'h75;
  localparam logic [7:0] SC_DOWN     = 8'h72;
  localparam logic [7:0] SC_LEFT     = 8'h6B;
  localparam logic [7:0] SC_RIGHT    = 8'h74;

  // Bytes that follow E1 in the Pause sequence
  localparam logic [2:0] PAUSE_SKIP_LEN = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE_SKIP
  } state_e;

  function automatic logic is_stat_ok(input logic [7:0] code);
    return (code == SC_BAT_OK) || (code == SC_ACK);
  endfunction

  function automatic logic is_stat_err(input logic [7:0] code);
    return (code == SC_BAT_ERR0) || (code == SC_BAT_ERR1) || (code == SC_OVR0) ||
           (code == SC_OVR1) || (code == SC_RESEND);
  endfunction

  function automatic logic is_status(input logic [7:0] code);
    return is_stat_ok(code) || is_stat_err(code) || (code == SC_ECHO);
  endfunction

endpackage

// File: rtl/ps2_hex_map.sv
// rtl/ps2_hex_map.sv - combinational map of Set-2 key code to hex digit value
module ps2_hex_map (
  input  logic [7:0] code,
  output logic       valid,
  output logic [3:0] digit
);

  always_comb begin
    valid = 1'b1;
    digit = 4'h0;
    case (code)
      8'h45: digit = 4'h0;
      8'h16: digit = 4'h1;
      8'h1E: digit = 4'h2;
      8'h26: digit = 4'h3;
      8'h25: digit = 4'h4;
      8'h2E: digit = 4'h5;
      8'h36: digit = 4'h6;
      8'h3D: digit = 4'h7;
      8'h3E: digit = 4'h8;
      8'h46: digit = 4'h9;
      8'h1C: digit = 4'hA;
      8'h32: digit = 4'hB;
      8'h21: digit = 4'hC;
      8'h23: digit = 4'hD;
      8'h24: digit = 4'hE;
      8'h2B: digit = 4'hF;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// rtl/ps2_scancode_decoder.sv - folds E0/F0 prefixes, skips Pause, splits status bytes from key events
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int CNT_W       = 20
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       BYTE_VALID,
  input  logic [7:0] BYTE,
  input  logic       BYTE_ERR,
  output logic       KEY_VALID,
  output logic [7:0] KEY_CODE,
  output logic       KEY_EXT,
  output logic       KEY_BREAK,
  output logic       HEX_VALID,
  output logic [3:0] HEX_DIGIT,
  output logic [3:0] ARROWS,
  output logic       PAUSE,
  output logic       STAT_OK,
  output logic       STAT_ERR
);

  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYC);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       skip_q, skip_d;
  logic             key_valid_q, key_valid_d;
  logic [7:0]       key_code_q, key_code_d;
  logic             key_ext_q, key_ext_d;
  logic             key_break_q, key_break_d;
  logic             hex_valid_q, hex_valid_d;
  logic [3:0]       hex_digit_q, hex_digit_d;
  logic [3:0]       arrows_q, arrows_d;
  logic             pause_q, pause_d;
  logic             stat_ok_q, stat_ok_d;
  logic             stat_err_q, stat_err_d;

  logic             timeout;
  state_e           cur_state;
  logic             ev, ev_ext, ev_brk;
  logic             map_valid;
  logic [3:0]       map_digit;

  ps2_hex_map u_hex_map (
    .code  (BYTE),
    .valid (map_valid),
    .digit (map_digit)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    skip_d      = skip_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_break_d = key_break_q;
    hex_valid_d = 1'b0;
    hex_digit_d = hex_digit_q;
    arrows_d    = arrows_q;
    pause_d     = 1'b0;
    stat_ok_d   = 1'b0;
    stat_err_d  = 1'b0;
    ev          = 1'b0;
    ev_ext      = 1'b0;
    ev_brk      = 1'b0;

    // A stale prefix is dropped before the byte on the same cycle is decoded
    timeout   = (state_q != ST_IDLE) && (cnt_q == TO_MAX);
    cur_state = timeout ? ST_IDLE : state_q;
    if (timeout) state_d = ST_IDLE;

    if (BYTE_VALID || timeout) begin
      cnt_d = '0;
    end else if (state_q != ST_IDLE) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (BYTE_VALID) begin
      if (BYTE_ERR) begin
        stat_err_d = 1'b1;
        state_d    = ST_IDLE;
      end else if (cur_state == ST_PAUSE_SKIP) begin
        skip_d = skip_q - 3'd1;
        if (skip_q == 3'd1) begin
          pause_d = 1'b1;
          state_d = ST_IDLE;
        end
      end else if (is_status(BYTE)) begin
        stat_ok_d  = is_stat_ok(BYTE);
        stat_err_d = is_stat_err(BYTE);
        state_d    = ST_IDLE;
      end else begin
        case (cur_state)
          ST_IDLE: begin
            if (BYTE == SC_EXT) begin
              state_d = ST_EXT;
            end else if (BYTE == SC_BRK) begin
              state_d = ST_BRK;
            end else if (BYTE == SC_PAUSE) begin
              state_d = ST_PAUSE_SKIP;
              skip_d  = PAUSE_SKIP_LEN;
            end else begin
              ev = 1'b1;
            end
          end
          ST_EXT: begin
            if (BYTE == SC_BRK) begin
              state_d = ST_EXT_BRK;
            end else if (BYTE != SC_EXT) begin
              ev      = 1'b1;
              ev_ext  = 1'b1;
              state_d = ST_IDLE;
            end
          end
          ST_BRK: begin
            if (BYTE == SC_EXT) begin
              state_d = ST_EXT_BRK;
            end else if (BYTE != SC_BRK) begin
              ev      = 1'b1;
              ev_brk  = 1'b1;
              state_d = ST_IDLE;
            end
          end
          ST_EXT_BRK: begin
            if ((BYTE != SC_EXT) && (BYTE != SC_BRK)) begin
              ev      = 1'b1;
              ev_ext  = 1'b1;
              ev_brk  = 1'b1;
              state_d = ST_IDLE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    if (ev) begin
      key_valid_d = 1'b1;
      key_code_d  = BYTE;
      key_ext_d   = ev_ext;
      key_break_d = ev_brk;
      // Only extended codes are the cursor arrows; plain ones are keypad keys
      if (ev_ext) begin
        case (BYTE)
          SC_UP:    arrows_d[3] = ~ev_brk;
          SC_DOWN:  arrows_d[2] = ~ev_brk;
          SC_LEFT:  arrows_d[1] = ~ev_brk;
          SC_RIGHT: arrows_d[0] = ~ev_brk;
          default:  ;
        endcase
      end else if (!ev_brk && map_valid) begin
        hex_valid_d = 1'b1;
        hex_digit_d = map_digit;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      skip_q      <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_ext_q   <= 1'b0;
      key_break_q <= 1'b0;
      hex_valid_q <= 1'b0;
      hex_digit_q <= '0;
      arrows_q    <= '0;
      pause_q     <= 1'b0;
      stat_ok_q   <= 1'b0;
      stat_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      skip_q      <= skip_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_break_q <= key_break_d;
      hex_valid_q <= hex_valid_d;
      hex_digit_q <= hex_digit_d;
      arrows_q    <= arrows_d;
      pause_q     <= pause_d;
      stat_ok_q   <= stat_ok_d;
      stat_err_q  <= stat_err_d;
    end
  end

  assign KEY_VALID = key_valid_q;
  assign KEY_CODE  = key_code_q;
  assign KEY_EXT   = key_ext_q;
  assign KEY_BREAK = key_break_q;
  assign HEX_VALID = hex_valid_q;
  assign HEX_DIGIT = hex_digit_q;
  assign ARROWS    = arrows_q;
  assign PAUSE     = pause_q;
  assign STAT_OK   = stat_ok_q;
  assign STAT_ERR  = stat_err_q;

endmodule
